// File: rtl/bpss_xfer_seq_if.sv
// Bypass-descriptor bus for bpss_xfer_seq: copy command in, read/write
// descriptor requests out, read/write completions in.
// master = sequencer side, slave = host/command side.
interface bpss_xfer_seq_if #(
    parameter int unsigned VADDR_BITS = 48,
    parameter int unsigned LEN_BITS   = 28
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [VADDR_BITS-1:0] cmd_rd_vaddr;
    logic [VADDR_BITS-1:0] cmd_wr_vaddr;
    logic [LEN_BITS-1:0]   cmd_len;

    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [VADDR_BITS-1:0] rd_req_vaddr;
    logic [LEN_BITS-1:0]   rd_req_len;
    logic                  rd_req_last;

    logic                  wr_req_valid;
    logic                  wr_req_ready;
    logic [VADDR_BITS-1:0] wr_req_vaddr;
    logic [LEN_BITS-1:0]   wr_req_len;
    logic                  wr_req_last;

    logic                  rd_done_valid;
    logic                  rd_done_ready;
    logic                  wr_done_valid;
    logic                  wr_done_ready;

    modport master (
        input  cmd_valid, cmd_rd_vaddr, cmd_wr_vaddr, cmd_len,
        output cmd_ready,
        output rd_req_valid, rd_req_vaddr, rd_req_len, rd_req_last,
        input  rd_req_ready,
        output wr_req_valid, wr_req_vaddr, wr_req_len, wr_req_last,
        input  wr_req_ready,
        input  rd_done_valid, wr_done_valid,
        output rd_done_ready, wr_done_ready
    );

    modport slave (
        output cmd_valid, cmd_rd_vaddr, cmd_wr_vaddr, cmd_len,
        input  cmd_ready,
        input  rd_req_valid, rd_req_vaddr, rd_req_len, rd_req_last,
        output rd_req_ready,
        input  wr_req_valid, wr_req_vaddr, wr_req_len, wr_req_last,
        output wr_req_ready,
        output rd_done_valid, wr_done_valid,
        input  rd_done_ready, wr_done_ready
    );
endinterface

// File: rtl/bpss_xfer_seq.sv
// Copy-command sequencer for the descriptor bypass interface.
// Splits one command into CHUNK_BYTES-sized read and write descriptors,
// tracks outstanding completions per direction and pulses cmpl at the end.
// Optional macro BPSS_SEQ_STATS_EN enables the busy-cycle counter on
// stat_cycles; without it stat_cycles is tied to zero.
module bpss_xfer_seq #(
    parameter int unsigned VADDR_BITS      = 48,
    parameter int unsigned LEN_BITS        = 28,
    parameter int unsigned CHUNK_BYTES     = 4096,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    bpss_xfer_seq_if.master       bus,
    output logic                  busy,
    output logic                  cmpl,
    output logic                  err,
    output logic [31:0]           stat_cycles
);
    localparam int unsigned        CNT_W     = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [LEN_BITS-1:0] CHUNK_LEN = LEN_BITS'(CHUNK_BYTES);
    localparam logic [CNT_W-1:0]   MAX_OUT   = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_CMPL
    } state_t;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_busy;
    logic                  r_cmpl;
    logic                  r_err;

    // r_*_vaddr / r_*_rem always describe the next descriptor to issue,
    // so the presented request is simply a view of these registers.
    logic [VADDR_BITS-1:0] r_rd_vaddr,  r_wr_vaddr;
    logic [LEN_BITS-1:0]   r_rd_rem,    r_wr_rem;
    logic [LEN_BITS-1:0]   r_rd_len,    r_wr_len;
    logic                  r_rd_last,   r_wr_last;
    logic                  r_rd_valid,  r_wr_valid;
    logic [CNT_W-1:0]      r_rd_out,    r_wr_out;

    logic                  w_accept;
    logic                  w_rd_hs,     w_wr_hs;
    logic                  w_rd_done,   w_wr_done;
    logic                  w_spurious;
    logic [VADDR_BITS-1:0] w_rd_vaddr_nx, w_wr_vaddr_nx;
    logic [LEN_BITS-1:0]   w_rd_rem_nx,   w_wr_rem_nx;
    logic [CNT_W-1:0]      w_rd_out_nx,   w_wr_out_nx;

    function automatic logic [LEN_BITS-1:0] chunk_of(input logic [LEN_BITS-1:0] rem);
        return (rem > CHUNK_LEN) ? CHUNK_LEN : rem;
    endfunction

    assign w_accept   = bus.cmd_valid & r_cmd_ready;
    assign w_rd_hs    = r_rd_valid & bus.rd_req_ready;
    assign w_wr_hs    = r_wr_valid & bus.wr_req_ready;
    // A completion with nothing outstanding is dropped and only flags err.
    assign w_rd_done  = bus.rd_done_valid & (r_rd_out != '0);
    assign w_wr_done  = bus.wr_done_valid & (r_wr_out != '0);
    assign w_spurious = (bus.rd_done_valid & (r_rd_out == '0)) |
                        (bus.wr_done_valid & (r_wr_out == '0));

    // Read side: next descriptor position and outstanding count
    always_comb begin
        w_rd_vaddr_nx = r_rd_vaddr;
        w_rd_rem_nx   = r_rd_rem;
        if (w_accept) begin
            w_rd_vaddr_nx = bus.cmd_rd_vaddr;
            w_rd_rem_nx   = bus.cmd_len;
        end else if (w_rd_hs) begin
            w_rd_vaddr_nx = r_rd_vaddr + VADDR_BITS'(r_rd_len);
            w_rd_rem_nx   = r_rd_rem - r_rd_len;
        end
        w_rd_out_nx = r_rd_out + CNT_W'(w_rd_hs) - CNT_W'(w_rd_done);
    end

    // Write side: next descriptor position and outstanding count
    always_comb begin
        w_wr_vaddr_nx = r_wr_vaddr;
        w_wr_rem_nx   = r_wr_rem;
        if (w_accept) begin
            w_wr_vaddr_nx = bus.cmd_wr_vaddr;
            w_wr_rem_nx   = bus.cmd_len;
        end else if (w_wr_hs) begin
            w_wr_vaddr_nx = r_wr_vaddr + VADDR_BITS'(r_wr_len);
            w_wr_rem_nx   = r_wr_rem - r_wr_len;
        end
        w_wr_out_nx = r_wr_out + CNT_W'(w_wr_hs) - CNT_W'(w_wr_done);
    end

    // Descriptor registers: valid/len/last are precomputed from the next
    // position, so they hold steady while a request waits for ready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_vaddr <= '0;
            r_rd_rem   <= '0;
            r_rd_len   <= '0;
            r_rd_last  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_out   <= '0;
            r_wr_vaddr <= '0;
            r_wr_rem   <= '0;
            r_wr_len   <= '0;
            r_wr_last  <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_out   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rd_vaddr <= w_rd_vaddr_nx;
            r_rd_rem   <= w_rd_rem_nx;
            r_rd_len   <= chunk_of(w_rd_rem_nx);
            r_rd_last  <= (w_rd_rem_nx != '0) && (w_rd_rem_nx <= CHUNK_LEN);
            r_rd_valid <= (w_rd_rem_nx != '0) && (w_rd_out_nx < MAX_OUT);
            r_rd_out   <= w_rd_out_nx;
            r_wr_vaddr <= w_wr_vaddr_nx;
            r_wr_rem   <= w_wr_rem_nx;
            r_wr_len   <= chunk_of(w_wr_rem_nx);
            r_wr_last  <= (w_wr_rem_nx != '0) && (w_wr_rem_nx <= CHUNK_LEN);
            r_wr_valid <= (w_wr_rem_nx != '0) && (w_wr_out_nx < MAX_OUT);
            r_wr_out   <= w_wr_out_nx;
            if (w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    // Control FSM with registered cmd_ready / busy / cmpl
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_cmpl      <= 1'b0;
        end else begin
            r_cmpl <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        if (bus.cmd_len != '0) begin
                            r_state <= ST_ISSUE;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_CMPL;
                            r_cmpl  <= 1'b1;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if ((w_rd_rem_nx == '0) && (w_wr_rem_nx == '0)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((w_rd_out_nx == '0) && (w_wr_out_nx == '0)) begin
                        r_state <= ST_CMPL;
                        r_busy  <= 1'b0;
                        r_cmpl  <= 1'b1;
                    end
                end
                ST_CMPL: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef BPSS_SEQ_STATS_EN
    logic [31:0] r_stat_cycles;

    // Busy-cycle counter, restarted by each accepted command, saturating
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_stat_cycles <= '0;
        end else if (w_accept) begin
            r_stat_cycles <= '0;
        end else if (r_busy && (r_stat_cycles != '1)) begin
            r_stat_cycles <= r_stat_cycles + 32'd1;
        end
    end

    assign stat_cycles = r_stat_cycles;
`else
    assign stat_cycles = '0;
`endif

    assign bus.cmd_ready     = r_cmd_ready;
    assign bus.rd_req_valid  = r_rd_valid;
    assign bus.rd_req_vaddr  = r_rd_vaddr;
    assign bus.rd_req_len    = r_rd_len;
    assign bus.rd_req_last   = r_rd_last;
    assign bus.wr_req_valid  = r_wr_valid;
    assign bus.wr_req_vaddr  = r_wr_vaddr;
    assign bus.wr_req_len    = r_wr_len;
    assign bus.wr_req_last   = r_wr_last;
    assign bus.rd_done_ready = 1'b1;
    assign bus.wr_done_ready = 1'b1;
    assign busy              = r_busy;
    assign cmpl              = r_cmpl;
    assign err               = r_err;
endmodule

// File: tb/tb_bpss_xfer_seq.sv
// Directed bench for bpss_xfer_seq (CHUNK_BYTES=4096, MAX_OUTSTANDING=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bpss_xfer_seq;
    localparam int unsigned VB = 48;
    localparam int unsigned LB = 28;

    logic          aclk    = 1'b0;
    logic          aresetn = 1'b0;
    logic          busy, cmpl, err;
    logic [31:0]   stat_cycles;

    int errors = 0;
    int checks = 0;

    bpss_xfer_seq_if #(.VADDR_BITS(VB), .LEN_BITS(LB)) bus ();

    bpss_xfer_seq #(
        .VADDR_BITS(VB),
        .LEN_BITS(LB),
        .CHUNK_BYTES(4096),
        .MAX_OUTSTANDING(8)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus.master),
        .busy(busy),
        .cmpl(cmpl),
        .err(err),
        .stat_cycles(stat_cycles)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [VB-1:0] ra, input logic [VB-1:0] wa, input logic [LB-1:0] len);
        int unsigned w = 0;
        while (!bus.cmd_ready && w < 20) begin
            tick();
            w++;
        end
        chk("cmd_ready_wait", bus.cmd_ready, 1'b1);
        bus.cmd_valid    = 1'b1;
        bus.cmd_rd_vaddr = ra;
        bus.cmd_wr_vaddr = wa;
        bus.cmd_len      = len;
        tick();
        bus.cmd_valid    = 1'b0;
    endtask

    logic [VB-1:0] rd_a [0:3];
    logic [LB-1:0] rd_l [0:3];
    logic          rd_t [0:3];
    logic [VB-1:0] wr_a [0:3];
    logic [LB-1:0] wr_l [0:3];
    logic          wr_t [0:3];
    int            rd_n, wr_n, busy_cnt;
    logic [VB-1:0] cap_a;
    logic [LB-1:0] cap_l;
    logic          cap_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid     = 1'b0;
        bus.cmd_rd_vaddr  = '0;
        bus.cmd_wr_vaddr  = '0;
        bus.cmd_len       = '0;
        bus.rd_req_ready  = 1'b0;
        bus.wr_req_ready  = 1'b0;
        bus.rd_done_valid = 1'b0;
        bus.wr_done_valid = 1'b0;

        // ---- reset state
        repeat (3) tick();
        chk("rst_cmd_ready", bus.cmd_ready, 1'b0);
        chk("rst_rd_valid", bus.rd_req_valid, 1'b0);
        chk("rst_wr_valid", bus.wr_req_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmpl", cmpl, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_stat", stat_cycles, 32'd0);
        aresetn = 1'b1;
        tick();
        chk("idle_cmd_ready", bus.cmd_ready, 1'b1);

        // ---- zero-length command: cmpl the cycle after accept, never busy
        send_cmd(48'h0000_0000_1000, 48'h0000_0000_2000, 28'd0);
        chk("z_cmpl", cmpl, 1'b1);
        chk("z_busy", busy, 1'b0);
        chk("z_rd_valid", bus.rd_req_valid, 1'b0);
        chk("z_wr_valid", bus.wr_req_valid, 1'b0);
        chk("z_cmd_ready", bus.cmd_ready, 1'b0);
        tick();
        chk("z_cmpl_drop", cmpl, 1'b0);
        chk("z_busy2", busy, 1'b0);
        tick();
        chk("z_ready_back", bus.cmd_ready, 1'b1);

        // ---- 10000 bytes, readies high: 4096, 4096, 1808
        bus.rd_req_ready = 1'b1;
        bus.wr_req_ready = 1'b1;
        send_cmd(48'h0000_1234_0000, 48'h0000_8000_0100, 28'd10000);
        chk("t2_first_rd_valid", bus.rd_req_valid, 1'b1);
        chk("t2_first_wr_valid", bus.wr_req_valid, 1'b1);
        chk("t2_busy", busy, 1'b1);
        chk("t2_cmd_ready", bus.cmd_ready, 1'b0);
        rd_n = 0;
        wr_n = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.rd_req_valid && bus.rd_req_ready && rd_n < 4) begin
                rd_a[rd_n] = bus.rd_req_vaddr;
                rd_l[rd_n] = bus.rd_req_len;
                rd_t[rd_n] = bus.rd_req_last;
                rd_n++;
            end
            if (bus.wr_req_valid && bus.wr_req_ready && wr_n < 4) begin
                wr_a[wr_n] = bus.wr_req_vaddr;
                wr_l[wr_n] = bus.wr_req_len;
                wr_t[wr_n] = bus.wr_req_last;
                wr_n++;
            end
            tick();
        end
        chk("t2_rd_count", rd_n, 3);
        chk("t2_wr_count", wr_n, 3);
        chk("t2_rd0", {rd_a[0], rd_l[0], rd_t[0]}, {48'h0000_1234_0000, 28'd4096, 1'b0});
        chk("t2_rd1", {rd_a[1], rd_l[1], rd_t[1]}, {48'h0000_1234_1000, 28'd4096, 1'b0});
        chk("t2_rd2", {rd_a[2], rd_l[2], rd_t[2]}, {48'h0000_1234_2000, 28'd1808, 1'b1});
        chk("t2_wr0", {wr_a[0], wr_l[0], wr_t[0]}, {48'h0000_8000_0100, 28'd4096, 1'b0});
        chk("t2_wr1", {wr_a[1], wr_l[1], wr_t[1]}, {48'h0000_8000_1100, 28'd4096, 1'b0});
        chk("t2_wr2", {wr_a[2], wr_l[2], wr_t[2]}, {48'h0000_8000_2100, 28'd1808, 1'b1});
        chk("t2_rd_idle", bus.rd_req_valid, 1'b0);
        chk("t2_drain_busy", busy, 1'b1);
        chk("t2_done_ready", {bus.rd_done_ready, bus.wr_done_ready}, 2'b11);
        bus.rd_done_valid = 1'b1;
        bus.wr_done_valid = 1'b1;
        tick();
        tick();
        chk("t2_no_early_cmpl", cmpl, 1'b0);
        tick();
        bus.rd_done_valid = 1'b0;
        bus.wr_done_valid = 1'b0;
        chk("t2_cmpl", cmpl, 1'b1);
        chk("t2_busy_drop", busy, 1'b0);
        chk("t2_err", err, 1'b0);
        tick();
        chk("t2_cmpl_pulse", cmpl, 1'b0);
        chk("t2_ready_back", bus.cmd_ready, 1'b1);

        // ---- 65536 bytes with dones withheld: outstanding limit of 8
        send_cmd(48'h0000_0001_0000, 48'h0000_0002_0000, 28'd65536);
        rd_n = 0;
        wr_n = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.rd_req_valid && bus.rd_req_ready) rd_n++;
            if (bus.wr_req_valid && bus.wr_req_ready) wr_n++;
            tick();
        end
        chk("t3_rd_issued", rd_n, 8);
        chk("t3_wr_issued", wr_n, 8);
        chk("t3_rd_stalled", bus.rd_req_valid, 1'b0);
        chk("t3_wr_stalled", bus.wr_req_valid, 1'b0);
        bus.rd_done_valid = 1'b1;
        tick();
        bus.rd_done_valid = 1'b0;
        rd_n = 0;
        wr_n = 0;
        cap_a = '0;
        for (int c = 0; c < 10; c++) begin
            if (bus.rd_req_valid && bus.rd_req_ready) begin
                rd_n++;
                cap_a = bus.rd_req_vaddr;
            end
            if (bus.wr_req_valid && bus.wr_req_ready) wr_n++;
            tick();
        end
        chk("t3_rd_one_more", rd_n, 1);
        chk("t3_rd_ninth_addr", cap_a, 48'h0000_0001_8000);
        chk("t3_wr_none", wr_n, 0);
        chk("t3_busy", busy, 1'b1);

        // ---- asynchronous reset in the middle of the transfer
        aresetn = 1'b0;
        #1;
        chk("t3_rst_valids", {bus.rd_req_valid, bus.wr_req_valid}, 2'b00);
        chk("t3_rst_status", {bus.cmd_ready, busy, cmpl, err}, 4'b0000);
        chk("t3_rst_stat", stat_cycles, 32'd0);
        tick();
        aresetn = 1'b1;
        tick();
        chk("t3_post_rst_ready", bus.cmd_ready, 1'b1);

        // ---- spurious read completion while nothing outstanding
        bus.rd_done_valid = 1'b1;
        tick();
        bus.rd_done_valid = 1'b0;
        chk("t4_err_set", err, 1'b1);
        chk("t4_still_idle", {bus.rd_req_valid, busy}, 2'b00);

        // ---- 20000 bytes, read address wraps, read ready low for 5 cycles
        send_cmd(48'hFFFF_FFFF_E000, 48'h0000_0040_0000, 28'd20000);
        tick();
        tick();
        bus.rd_req_ready = 1'b0;
        wr_n = 0;
        for (int k = 0; k < 5; k++) begin
            chk("t4_hold_valid", bus.rd_req_valid, 1'b1);
            chk("t4_hold_desc", {bus.rd_req_vaddr, bus.rd_req_len, bus.rd_req_last},
                {48'h0000_0000_0000, 28'd4096, 1'b0});
            if (bus.wr_req_valid && bus.wr_req_ready) wr_n++;
            tick();
        end
        chk("t4_wr_progress", wr_n, 3);
        chk("t4_wr_finished", bus.wr_req_valid, 1'b0);
        bus.rd_req_ready = 1'b1;
        rd_n = 0;
        cap_a = '0;
        cap_l = '0;
        cap_t = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.rd_req_valid && bus.rd_req_ready) begin
                rd_n++;
                cap_a = bus.rd_req_vaddr;
                cap_l = bus.rd_req_len;
                cap_t = bus.rd_req_last;
            end
            tick();
        end
        chk("t4_rd_rest", rd_n, 3);
        chk("t4_rd_last_desc", {cap_a, cap_l, cap_t}, {48'h0000_0000_2000, 28'd3616, 1'b1});
        bus.rd_done_valid = 1'b1;
        bus.wr_done_valid = 1'b1;
        repeat (5) tick();
        bus.rd_done_valid = 1'b0;
        bus.wr_done_valid = 1'b0;
        chk("t4_cmpl", cmpl, 1'b1);
        chk("t4_err_sticky", err, 1'b1);
        tick();
        chk("t4_cmpl_pulse", cmpl, 1'b0);
        chk("t4_err_sticky2", err, 1'b1);

        // ---- 4096 bytes, completions 3 cycles after issue; busy-cycle stats
        send_cmd(48'h0000_0100_0000, 48'h0000_0200_0000, 28'd4096);
        busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy) busy_cnt++;
            if (cmpl) break;
            bus.rd_done_valid = (c == 3);
            bus.wr_done_valid = (c == 3);
            tick();
        end
        bus.rd_done_valid = 1'b0;
        bus.wr_done_valid = 1'b0;
        chk("t5_cmpl", cmpl, 1'b1);
        chk("t5_busy_cycles", busy_cnt, 4);
`ifdef BPSS_SEQ_STATS_EN
        chk("t5_stat", stat_cycles, 32'(busy_cnt));
        repeat (3) tick();
        chk("t5_stat_hold", stat_cycles, 32'(busy_cnt));
`else
        chk("t5_stat_off", stat_cycles, 32'd0);
        repeat (3) tick();
        chk("t5_stat_off_hold", stat_cycles, 32'd0);
`endif
        chk("t5_ready_back", bus.cmd_ready, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
